// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter states, line levels and default bit timing.
`default_nettype none

package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam logic LINE_IDLE  = 1'b1;
   localparam logic LINE_START = 1'b0;

   localparam int DEFAULT_CLK_PER_BIT = 50;

endpackage

`default_nettype wire

// File: rtl/byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO with a registered occupancy count.
`default_nettype none

module byte_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (!do_push && do_pop) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter fed through a small byte FIFO.
// Define UART_TX_PARITY_EN for 8E1 frames with an even-parity bit before the stop bit.
`default_nettype none

module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       new_tx_data,
   input  logic       block,
   output logic       tx_busy,
   output logic       overflow,
   output logic       tx
);

   localparam int             CNT_W    = $clog2(CLK_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift;
   logic [7:0]       fifo_dout;
   logic             fifo_full;
   logic             fifo_empty;
   logic             push;
   logic             pop;
   logic             bit_end;
`ifdef UART_TX_PARITY_EN
   logic             parity_bit;
`endif

   assign tx_busy = fifo_full;
   assign push    = new_tx_data && !fifo_full;
   assign bit_end = (cnt == CNT_LAST);
   // A frame may start from IDLE or straight out of the last stop-bit cycle.
   assign pop     = !fifo_empty && !block &&
                    ((state == IDLE) || ((state == STOP) && bit_end));

   byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (tx_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         tx       <= LINE_IDLE;
         overflow <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         if (new_tx_data && fifo_full) begin
            overflow <= 1'b1;
         end

         if (pop) begin
            state <= START;
            cnt   <= '0;
            shift <= fifo_dout;
            tx    <= LINE_START;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^fifo_dout;
`endif
         end else begin
            case (state)
               IDLE: begin
                  cnt <= '0;
               end
               START: begin
                  if (bit_end) begin
                     state <= DATA;
                     cnt   <= '0;
                     tx    <= shift[0];
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               DATA: begin
                  if (bit_end) begin
                     cnt <= '0;
                     if (bit_idx == 3'd7) begin
                        bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                        state <= PARITY;
                        tx    <= parity_bit;
`else
                        state <= STOP;
                        tx    <= LINE_IDLE;
`endif
                     end else begin
                        bit_idx <= bit_idx + 1'b1;
                        shift   <= shift >> 1;
                        tx      <= shift[1];
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
`ifdef UART_TX_PARITY_EN
               PARITY: begin
                  if (bit_end) begin
                     state <= STOP;
                     cnt   <= '0;
                     tx    <= LINE_IDLE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
`endif
               STOP: begin
                  if (bit_end) begin
                     state <= IDLE;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
                  tx    <= LINE_IDLE;
               end
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: frame-level reference model plus directed checks.
`default_nettype none

module tb_uart_tx_buffered;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int FRAME_LEN = FRAME_BITS * CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       new_tx_data = 1'b0;
   logic       block = 1'b0;
   logic       tx_busy;
   logic       overflow;
   logic       tx;

   int n_checks = 0;
   int n_fail   = 0;

   uart_tx_buffered #(
      .CLK_PER_BIT (CPB),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .tx_data     (tx_data),
      .new_tx_data (new_tx_data),
      .block       (block),
      .tx_busy     (tx_busy),
      .overflow    (overflow),
      .tx          (tx)
   );

   always #5 clk = ~clk;

   // Inputs as the DUT saw them on the latest rising edge.
   logic       s_rst, s_new, s_block;
   logic [7:0] s_data;
   always @(posedge clk) begin
      s_rst   <= rst;
      s_new   <= new_tx_data;
      s_block <= block;
      s_data  <= tx_data;
   end

   // Reference model: queue of accepted bytes and a position within the current frame.
   logic [7:0] mq[$];
   logic       m_bits [FRAME_BITS];
   logic       m_active = 1'b0;
   int         m_pos    = 0;
   logic       m_ovf    = 1'b0;
   logic       m_tx     = 1'b1;

   task automatic model_step();
      logic       ending;
      logic       start;
      logic       was_full;
      logic [7:0] b;
      if (!s_rst) begin
         mq.delete();
         m_active = 1'b0;
         m_pos    = 0;
         m_ovf    = 1'b0;
      end else begin
         ending   = m_active && (m_pos == FRAME_LEN - 1);
         start    = (!m_active || ending) && (mq.size() != 0) && !s_block;
         was_full = (mq.size() == DEPTH);
         if (start) begin
            b = mq.pop_front();
            m_bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) m_bits[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
            m_bits[9]  = ^b;
            m_bits[10] = 1'b1;
`else
            m_bits[9]  = 1'b1;
`endif
            m_pos    = 0;
            m_active = 1'b1;
         end else if (m_active) begin
            if (ending) m_active = 1'b0;
            else        m_pos++;
         end
         if (s_new) begin
            if (was_full) m_ovf = 1'b1;
            else          mq.push_back(s_data);
         end
      end
      m_tx = m_active ? m_bits[m_pos / CPB] : 1'b1;
   endtask

   task automatic check(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         model_step();
         check("model_tx", tx, m_tx);
         check("model_tx_busy", tx_busy, mq.size() == DEPTH);
         check("model_overflow", overflow, m_ovf);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic write_byte(input logic [7:0] b);
      new_tx_data = 1'b1;
      tx_data     = b;
      tick(1);
      new_tx_data = 1'b0;
   endtask

   logic exp_a [10];
   logic [7:0] burst [6];

   initial begin
      exp_a = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

      // Reset held for three cycles
      rst = 1'b0;
      tick(3);
      check("reset_tx", tx, 1'b1);
      check("reset_busy", tx_busy, 1'b0);
      check("reset_overflow", overflow, 1'b0);
      rst = 1'b1;
      tick(2);

      // Single byte 'A'
      write_byte(8'h41);
      check("a_tx_before_pop", tx, 1'b1);
      tick(1);
      check("a_start_latency", tx, 1'b0);
      tick(2);
      for (int k = 0; k < 10; k++) begin
         check($sformatf("a_bit%0d", k), tx, exp_a[k]);
         tick(4);
      end
      check("a_idle_after", tx, 1'b1);
      tick(3);

      // Burst of six strobes into an empty FIFO
      for (int k = 0; k < 6; k++) begin
         if (k == 5) check("burst_busy_full", tx_busy, 1'b1);
         new_tx_data = 1'b1;
         tx_data     = burst[k];
         tick(1);
      end
      new_tx_data = 1'b0;
      check("burst_overflow", overflow, 1'b1);
      check("burst_busy_held", tx_busy, 1'b1);
      n_checks++;
      if (mq.size() != 4) begin
         n_fail++;
         $display("FAIL burst_model_depth: got %0d expected 4", mq.size());
      end
      tick(5 * FRAME_LEN + 10);
      check("burst_drained_idle", tx, 1'b1);
      check("burst_drained_busy", tx_busy, 1'b0);

      // Host flow control
      block = 1'b1;
      write_byte(8'hA5);
      write_byte(8'h3C);
      tick(10);
      check("block_holds_line", tx, 1'b1);
      block = 1'b0;
      tick(1);
      check("block_release_start", tx, 1'b0);
      tick(19);
      block = 1'b1;
      tick(30);
      check("block_no_next_frame", tx, 1'b1);
      block = 1'b0;
      tick(1);
      check("block_second_start", tx, 1'b0);
      tick(FRAME_LEN + 5);

      // Reset in the middle of a 0xFF frame with another byte queued
      write_byte(8'hFF);
      write_byte(8'h12);
      tick(15);
      rst = 1'b0;
      tick(1);
      check("midreset_tx", tx, 1'b1);
      check("midreset_busy", tx_busy, 1'b0);
      check("midreset_overflow", overflow, 1'b0);
      rst = 1'b1;
      tick(50);
      check("midreset_no_frames", tx, 1'b1);

`ifdef UART_TX_PARITY_EN
      write_byte(8'h41);
      tick(1 + 38);
      check("par_41_bit", tx, 1'b0);
      tick(6);
      check("par_41_idle", tx, 1'b1);
      tick(3);
      write_byte(8'h07);
      tick(1 + 38);
      check("par_07_bit", tx, 1'b1);
      tick(10);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
